// File: rtl/memory_stage_if.sv
// Pipeline-side signals of the Y86-64 memory stage: inputs latched from execute,
// stall/bubble control from the hazard unit, and M/m/W values leaving the stage.
interface memory_stage_if;
  // execute -> M register
  logic [3:0]  e_icode;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [63:0] e_valP;
  logic        e_cnd;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [2:0]  e_stat;

  // hazard unit control
  logic        M_stall;
  logic        M_bubble;
  logic        W_stall;

  // M register and memory-stage values for forwarding / exception control
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;

  // W register to write-back
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  // Surrounding pipeline side
  modport master (
    output e_icode, e_valE, e_valA, e_valP, e_cnd, e_dstE, e_dstM, e_stat,
    output M_stall, M_bubble, W_stall,
    input  M_icode, M_valE, M_dstE, M_dstM, m_valM, m_stat,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  // Memory stage side
  modport slave (
    input  e_icode, e_valE, e_valA, e_valP, e_cnd, e_dstE, e_dstM, e_stat,
    input  M_stall, M_bubble, W_stall,
    output M_icode, M_valE, M_dstE, M_dstM, m_valM, m_stat,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, 8-byte little-endian data memory,
// address-error detection and the W pipeline register feeding write-back.
module memory_stage #(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DMEM_BYTES);
  // Highest legal base address of an 8-byte access
  localparam logic [63:0] LastBase = 64'(DMEM_BYTES - 8);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatAdr = 3'd3;

  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] ICmov   = 4'h2;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_p;
    logic        cnd;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  stat;
  } m_reg_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam m_reg_t MBubble = '{
    icode: INop, val_e: 64'h0, val_a: 64'h0, val_p: 64'h0,
    cnd: 1'b0, dst_e: RNone, dst_m: RNone, stat: StatAok
  };

  localparam w_reg_t WBubble = '{
    stat: StatAok, icode: INop, val_e: 64'h0, val_m: 64'h0,
    dst_e: RNone, dst_m: RNone
  };

  m_reg_t      m_q, m_load;
  w_reg_t      w_q, w_load;

  logic        mem_read, mem_write, dmem_error, write_en;
  logic [63:0] addr, wdata, m_val_m;
  logic [2:0]  m_stat_c;

  // Data memory; contents deliberately not reset
  logic [7:0]  mem [DMEM_BYTES];

  // cnd is only needed to squash dstE at load time
  logic        unused_m_cnd;
  assign unused_m_cnd = m_q.cnd;

  // Next M contents from execute, with a not-taken cmov dropping its destination
  always_comb begin
    m_load.icode = bus.e_icode;
    m_load.val_e = bus.e_valE;
    m_load.val_a = bus.e_valA;
    m_load.val_p = bus.e_valP;
    m_load.cnd   = bus.e_cnd;
    m_load.dst_e = bus.e_dstE;
    m_load.dst_m = bus.e_dstM;
    m_load.stat  = bus.e_stat;
    if (bus.e_icode == ICmov && !bus.e_cnd) begin
      m_load.dst_e = RNone;
    end
  end

  // M pipeline register: stall beats bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= MBubble;
    end else if (bus.M_stall) begin
      m_q <= m_q;
    end else if (bus.M_bubble) begin
      m_q <= MBubble;
    end else begin
      m_q <= m_load;
    end
  end

  // Decode memory operation and address from the M-stage instruction
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = m_q.val_e;
    wdata     = m_q.val_a;
    case (m_q.icode)
      IRmmovq, IPushq: mem_write = 1'b1;
      ICall: begin
        mem_write = 1'b1;
        wdata     = m_q.val_p;
      end
      IMrmovq: mem_read = 1'b1;
      IRet, IPopq: begin
        mem_read = 1'b1;
        addr     = m_q.val_a;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so huge addresses cannot wrap into range
  assign dmem_error = (mem_read || mem_write) && (addr > LastBase);
  assign m_stat_c   = dmem_error ? StatAdr : m_q.stat;

  // Held W means the instruction will be presented again, so commit only once
  assign write_en = mem_write && !dmem_error && (m_q.stat == StatAok) && !bus.W_stall;

  // Combinational little-endian read; zero when idle or faulting
  always_comb begin
    m_val_m = 64'h0;
    if (mem_read && !dmem_error) begin
      for (int i = 0; i < 8; i++) begin
        m_val_m[8*i +: 8] = mem[addr[AW-1:0] + AW'(i)];
      end
    end
  end

  // Little-endian 8-byte store; a reset forces M to a bubble, so nothing writes under rst
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr[AW-1:0] + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Next W contents from the memory stage
  always_comb begin
    w_load.stat  = m_stat_c;
    w_load.icode = m_q.icode;
    w_load.val_e = m_q.val_e;
    w_load.val_m = m_val_m;
    w_load.dst_e = m_q.dst_e;
    w_load.dst_m = m_q.dst_m;
  end

  // W pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= WBubble;
    end else if (!bus.W_stall) begin
      w_q <= w_load;
    end
  end

  assign bus.M_icode = m_q.icode;
  assign bus.M_valE  = m_q.val_e;
  assign bus.M_dstE  = m_q.dst_e;
  assign bus.M_dstM  = m_q.dst_m;
  assign bus.m_valM  = m_val_m;
  assign bus.m_stat  = m_stat_c;

  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.val_e;
  assign bus.W_valM  = w_q.val_m;
  assign bus.W_dstE  = w_q.dst_e;
  assign bus.W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stores/loads, stack ops, address faults,
// stall/bubble priority, cmov squash, W stall and asynchronous reset.
module tb_memory_stage;

  localparam logic [3:0] NoReg = 4'hF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage #(.DMEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] icode, input logic [63:0] val_e, input logic [63:0] val_a,
                       input logic [3:0] dst_e, input logic [3:0] dst_m, input logic cnd = 1'b0,
                       input logic [2:0] stat = 3'd1, input logic [63:0] val_p = 64'h0);
    bus.e_icode = icode;
    bus.e_valE  = val_e;
    bus.e_valA  = val_a;
    bus.e_valP  = val_p;
    bus.e_cnd   = cnd;
    bus.e_dstE  = dst_e;
    bus.e_dstM  = dst_m;
    bus.e_stat  = stat;
  endtask

  task automatic nop();
    issue(4'h1, 64'h0, 64'h0, NoReg, NoReg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mbyte(input logic [9:0] a);
    return 64'(dut.mem[a]);
  endfunction

  initial begin
    rst          = 1'b1;
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b0;
    nop();
    tick();
    tick();
    check("rst_M_icode", 64'(bus.M_icode), 64'h1);
    check("rst_M_dstE", 64'(bus.M_dstE), 64'hF);
    check("rst_W_stat", 64'(bus.W_stat), 64'h1);
    check("rst_W_dstM", 64'(bus.W_dstM), 64'hF);
    check("rst_W_valM", bus.W_valM, 64'h0);
    rst = 1'b0;

    // Preload known memory contents
    issue(4'h4, 64'h20, 64'h11, NoReg, NoReg); tick();
    issue(4'h4, 64'h30, 64'h77, NoReg, NoReg); tick();
    issue(4'h4, 64'h40, 64'h33, NoReg, NoReg); tick();
    issue(4'h8, 64'h50, 64'h0, 4'h4, NoReg, 1'b0, 3'd1, 64'hCAFE); tick();
    nop(); tick();
    check("pre_0x20", mbyte(10'h20), 64'h11);
    check("pre_0x30", mbyte(10'h30), 64'h77);
    check("call_lo", mbyte(10'h50), 64'hFE);
    check("call_hi", mbyte(10'h51), 64'hCA);

    // Asynchronous reset between edges while a store sits in M
    issue(4'h4, 64'h30, 64'h5A, NoReg, NoReg); tick();
    check("mid_M_icode_pre", 64'(bus.M_icode), 64'h4);
    nop();
    #2 rst = 1'b1;
    #1;
    check("mid_M_icode", 64'(bus.M_icode), 64'h1);
    check("mid_W_stat", 64'(bus.W_stat), 64'h1);
    check("mid_W_dstE", 64'(bus.W_dstE), 64'hF);
    tick();
    check("mid_no_write", mbyte(10'h30), 64'h77);
    rst = 1'b0;

    // Store then immediate load of the same address
    issue(4'h4, 64'h10, 64'h1122334455667788, NoReg, NoReg); tick();
    check("st_M_valE", bus.M_valE, 64'h10);
    issue(4'h5, 64'h10, 64'h0, NoReg, 4'h3); tick();
    check("ld_m_valM", bus.m_valM, 64'h1122334455667788);
    check("byte_0x10", mbyte(10'h10), 64'h88);
    check("byte_0x17", mbyte(10'h17), 64'h11);
    nop(); tick();
    check("ld_W_valM", bus.W_valM, 64'h1122334455667788);
    check("ld_W_dstM", 64'(bus.W_dstM), 64'h3);
    check("ld_W_stat", 64'(bus.W_stat), 64'h1);

    // pushq at the last legal address, then popq
    issue(4'hA, 64'h3F8, 64'hAB, 4'h4, NoReg); tick();
    issue(4'hB, 64'h400, 64'h3F8, 4'h4, 4'h5); tick();
    check("pop_m_valM", bus.m_valM, 64'hAB);
    check("pop_m_stat", 64'(bus.m_stat), 64'h1);
    nop(); tick();
    check("pop_W_valE", bus.W_valE, 64'h400);
    check("pop_W_valM", bus.W_valM, 64'hAB);

    // One past the last legal base address
    issue(4'h5, 64'd1017, 64'h0, NoReg, 4'h2); tick();
    check("oob_ld_m_stat", 64'(bus.m_stat), 64'h3);
    check("oob_ld_m_valM", bus.m_valM, 64'h0);
    issue(4'h4, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF, NoReg, NoReg); tick();
    check("oob_ld_W_stat", 64'(bus.W_stat), 64'h3);
    check("oob_ld_W_valM", bus.W_valM, 64'h0);
    issue(4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, NoReg, 4'h2); tick();
    check("oob_st_W_stat", 64'(bus.W_stat), 64'h3);
    check("oob_st_1017", mbyte(10'd1017), 64'h0);
    check("oob_st_1023", mbyte(10'd1023), 64'h0);
    check("oob_st_1016", mbyte(10'd1016), 64'hAB);
    check("wrap_m_stat", 64'(bus.m_stat), 64'h3);
    nop(); tick();

    // Halted instruction passes through with no memory side effect
    issue(4'h4, 64'h40, 64'h99, NoReg, NoReg, 1'b0, 3'd2); tick();
    check("hlt_m_stat", 64'(bus.m_stat), 64'h2);
    nop(); tick();
    check("hlt_W_stat", 64'(bus.W_stat), 64'h2);
    check("hlt_no_write", mbyte(10'h40), 64'h33);

    // Stall beats bubble, then bubble alone
    issue(4'h6, 64'h55, 64'h0, 4'h1, NoReg); tick();
    bus.M_stall  = 1'b1;
    bus.M_bubble = 1'b1;
    issue(4'h5, 64'h99, 64'h0, NoReg, 4'h7); tick();
    check("stall_M_icode", 64'(bus.M_icode), 64'h6);
    check("stall_M_valE", bus.M_valE, 64'h55);
    check("stall_M_dstE", 64'(bus.M_dstE), 64'h1);
    bus.M_stall = 1'b0;
    tick();
    check("bub_M_icode", 64'(bus.M_icode), 64'h1);
    check("bub_M_dstE", 64'(bus.M_dstE), 64'hF);
    check("bub_M_dstM", 64'(bus.M_dstM), 64'hF);
    bus.M_bubble = 1'b0;

    // cmov not taken squashes dstE; taken keeps it
    issue(4'h2, 64'h77, 64'h0, 4'h3, NoReg, 1'b0); tick();
    check("cmov0_M_dstE", 64'(bus.M_dstE), 64'hF);
    issue(4'h2, 64'h99, 64'h0, 4'h3, NoReg, 1'b1); tick();
    check("cmov1_M_dstE", 64'(bus.M_dstE), 64'h3);
    check("cmov0_W_dstE", 64'(bus.W_dstE), 64'hF);
    nop(); tick();
    check("cmov1_W_dstE", 64'(bus.W_dstE), 64'h3);
    check("cmov1_W_valE", bus.W_valE, 64'h99);

    // W stall holds W and defers the store until released
    issue(4'h4, 64'h20, 64'hDEAD, NoReg, NoReg); tick();
    check("ws_W_icode_pre", 64'(bus.W_icode), 64'h1);
    bus.M_stall = 1'b1;
    bus.W_stall = 1'b1;
    nop(); tick();
    check("ws_no_write", mbyte(10'h20), 64'h11);
    check("ws_W_hold", 64'(bus.W_icode), 64'h1);
    check("ws_M_hold", 64'(bus.M_icode), 64'h4);
    bus.M_stall = 1'b0;
    bus.W_stall = 1'b0;
    tick();
    check("ws_write_lo", mbyte(10'h20), 64'hAD);
    check("ws_write_hi", mbyte(10'h21), 64'hDE);
    check("ws_W_icode", 64'(bus.W_icode), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
